// File: rtl/simple_pkg.sv
// simple_pkg: shared definitions for the SIMPLE 16-bit datapath execute stage.
//   - state_t      : sequencer FSM states
//   - OP_*         : class-11 opcode values (instr[7:4])
//   - FLAG_*       : bit positions inside the SZCV flag nibble
//   - f_* helpers  : instruction field slices and legality/write-back decode
package simple_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] CLS_RR = 2'b11;

  function automatic logic [1:0] f_cls(input logic [15:0] i); return i[15:14]; endfunction
  function automatic logic [2:0] f_rs (input logic [15:0] i); return i[13:11]; endfunction
  function automatic logic [2:0] f_rd (input logic [15:0] i); return i[10:8];  endfunction
  function automatic logic [3:0] f_op (input logic [15:0] i); return i[7:4];   endfunction
  function automatic logic [3:0] f_d  (input logic [15:0] i); return i[3:0];   endfunction

  // Shifts take their B operand from the immediate d field.
  function automatic logic f_is_shift(input logic [3:0] op);
    return (op >= OP_SLL) && (op <= OP_SRA);
  endfunction

  function automatic logic f_legal(input logic [15:0] i);
    return (f_cls(i) == CLS_RR) && ((f_op(i) <= OP_MOV) || f_is_shift(f_op(i)));
  endfunction

  // CMP only updates flags; every other legal op writes R[Rd].
  function automatic logic f_writes_back(input logic [3:0] op);
    return op != OP_CMP;
  endfunction

endpackage

// File: rtl/reg_file8x16.sv
// reg_file8x16: 8 x 16-bit register file.
//   clk, rst_n          : clock, async active-low clear of all entries
//   we, waddr, wdata    : single write port (rising edge)
//   ra_addr/ra_data     : combinational read port A (Rd)
//   rb_addr/rb_data     : combinational read port B (Rs)
//   dbg_addr/dbg_data   : combinational debug read port
module reg_file8x16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra_addr,
  output logic [15:0] ra_data,
  input  logic [2:0]  rb_addr,
  output logic [15:0] rb_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [7:0][15:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_sequencer.sv
// alu_exec_sequencer: multi-cycle execute sequencer for class-11 instructions.
//   in_valid/in_instr/in_ready : instruction handshake (accept only in IDLE)
//   alu_ar/alu_br/alu_ir       : registered bus to the external combinational ALU
//   alu_out/alu_flags          : ALU result and SZCV, sampled at EXEC->WB
//   done/err                   : one-cycle retire / reject pulses
//   result/flags               : last retired value and architectural SZCV
//   wr_en/wr_addr/wr_data      : external register write, honoured in IDLE only
//   dbg_addr/dbg_data          : combinational register read-out
// Flow: IDLE -> READ -> EXEC -> WB -> IDLE, or IDLE -> ERR -> IDLE for illegal words.
module alu_exec_sequencer
  import simple_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic [15:0] alu_ar,
  output logic [15:0] alu_br,
  output logic [15:0] alu_ir,
  input  logic [3:0]  alu_flags,
  input  logic [15:0] alu_out,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [3:0]  flags,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  state_t      state;
  logic [15:0] ir_q;     // word captured at accept; indexes the register file in READ
  logic [15:0] rd_data;
  logic [15:0] rs_data;

  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  // The write-back happens on the WB->IDLE edge from the held result, so it is
  // visible on dbg_data the cycle after done. External writes only land in IDLE,
  // which also lets a write and an accept share a cycle with READ seeing the new value.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    if (state == WB) begin
      rf_we    = f_writes_back(f_op(alu_ir));
      rf_waddr = f_rd(alu_ir);
      rf_wdata = result;
    end else if (state == IDLE) begin
      rf_we    = wr_en;
    end
  end

  reg_file8x16 u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (f_rd(ir_q)),
    .ra_data  (rd_data),
    .rb_addr  (f_rs(ir_q)),
    .rb_data  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      ir_q     <= '0;
      alu_ar   <= '0;
      alu_br   <= '0;
      alu_ir   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      flags    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ir_q     <= in_instr;
            in_ready <= 1'b0;
            if (f_legal(in_instr)) begin
              state <= READ;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        READ: begin
          alu_ir <= ir_q;
          alu_ar <= rd_data;
          alu_br <= f_is_shift(f_op(ir_q)) ? {12'b0, f_d(ir_q)} : rs_data;
          state  <= EXEC;
        end
        EXEC: begin
          result <= alu_out;
          flags  <= alu_flags;
          done   <= 1'b1;
          state  <= WB;
        end
        WB: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural ALU on its bus.
module tb_alu_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic [15:0] alu_ar, alu_br, alu_ir;
  logic [3:0]  alu_flags;
  logic [15:0] alu_out;
  logic        done, err;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  alu_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .alu_ar(alu_ar), .alu_br(alu_br), .alu_ir(alu_ir),
    .alu_flags(alu_flags), .alu_out(alu_out),
    .done(done), .err(err), .result(result), .flags(flags),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: SZCV with C as carry/borrow and V as signed overflow.
  always_comb begin
    logic [16:0] s;
    logic        c, v;
    logic [15:0] a, b;
    a = alu_ar;
    b = alu_br;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (alu_ir[7:4])
      4'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[16]; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd1, 4'd5: begin s = {1'b0, a} - {1'b0, b}; c = s[16]; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd2: s = {1'b0, a & b};
      4'd3: s = {1'b0, a | b};
      4'd4: s = {1'b0, a ^ b};
      4'd6: s = {1'b0, b};
      4'd8: s = {1'b0, a << b[3:0]};
      4'd9: s = {1'b0, (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}))};
      4'd10: s = {1'b0, a >> b[3:0]};
      4'd11: s = {1'b0, $unsigned($signed(a) >>> b[3:0])};
      default: s = '0;
    endcase
    alu_out   = s[15:0];
    alu_flags = {s[15], (s[15:0] == 16'h0), c, v};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Returns number of edges after the accept edge until done is seen (2 expected).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic [15:0] instr, output int n);
    in_valid = 1'b1; in_instr = instr;
    tick();
    in_valid = 1'b0;
    wait_done(n);
  endtask

  task automatic issue_bad(input string tag, input logic [15:0] instr);
    in_valid = 1'b1; in_instr = instr;
    tick();
    in_valid = 1'b0;
    chk({tag, "_err"}, {15'b0, err}, 16'h1);
    chk({tag, "_nodone"}, {15'b0, done}, 16'h0);
    tick();
    chk({tag, "_ready"}, {15'b0, in_ready}, 16'h1);
    chk({tag, "_errlow"}, {15'b0, err}, 16'h0);
  endtask

  initial begin
    int n;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    tick(); tick();
    chk("rst_ready", {15'b0, in_ready}, 16'h1);
    chk("rst_done",  {15'b0, done}, 16'h0);
    chk("rst_err",   {15'b0, err}, 16'h0);
    chk("rst_result", result, 16'h0);
    chk("rst_flags", {12'b0, flags}, 16'h0);
    chk("rst_ar", alu_ar, 16'h0);
    chk("rst_br", alu_br, 16'h0);
    chk("rst_ir", alu_ir, 16'h0);
    rst_n = 1'b1;
    tick();

    // ADD R2 <- R2 + R1 : 5 + 3
    wr(3'd1, 16'h0003);
    wr(3'd2, 16'h0005);
    issue(16'hCA00, n);
    chk("add_lat", n[15:0], 16'd2);
    chk("add_result", result, 16'h0008);
    chk("add_flags", {12'b0, flags}, 16'h0);
    chk("add_ar", alu_ar, 16'h0005);
    chk("add_br", alu_br, 16'h0003);
    chk("add_ir", alu_ir, 16'hCA00);
    chk("add_busy", {15'b0, in_ready}, 16'h0);
    tick();
    chk("add_ready", {15'b0, in_ready}, 16'h1);
    chk("add_done_low", {15'b0, done}, 16'h0);
    rd_chk("add_r2", 3'd2, 16'h0008);

    // Signed overflow: 0x7FFF + 1
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h7FFF);
    issue(16'hCA00, n);
    chk("ovf_lat", n[15:0], 16'd2);
    chk("ovf_flags", {12'b0, flags}, 16'h0009);
    tick();
    rd_chk("ovf_r2", 3'd2, 16'h8000);

    // CMP equal: Z only, no write-back
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0005);
    issue(16'hCA50, n);
    chk("cmp_lat", n[15:0], 16'd2);
    chk("cmp_flags", {12'b0, flags}, 16'h0004);
    tick();
    rd_chk("cmp_r2", 3'd2, 16'h0005);

    // SLL R2 by immediate 4
    wr(3'd2, 16'h0001);
    issue(16'hC284, n);
    chk("sll_lat", n[15:0], 16'd2);
    chk("sll_br", alu_br, 16'h0004);
    chk("sll_flags", {12'b0, flags}, 16'h0);
    tick();
    rd_chk("sll_r2", 3'd2, 16'h0010);

    // Illegal class and illegal op: no state change
    issue_bad("bad_cls", 16'h0A00);
    issue_bad("bad_op", 16'hCAF0);
    rd_chk("bad_r2", 3'd2, 16'h0010);
    rd_chk("bad_r1", 3'd1, 16'h0005);
    chk("bad_flags", {12'b0, flags}, 16'h0);
    chk("bad_result", result, 16'h0010);

    // External write in the accept cycle: MOV sees the new R1
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234;
    in_valid = 1'b1; in_instr = 16'hCA60;
    tick();
    wr_en = 1'b0; in_valid = 1'b0;
    wait_done(n);
    chk("mov_lat", n[15:0], 16'd2);
    chk("mov_result", result, 16'h1234);
    tick();
    rd_chk("mov_r2", 3'd2, 16'h1234);

    // Reset during EXEC aborts the instruction
    in_valid = 1'b1; in_instr = 16'hCA00;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_done", {15'b0, done}, 16'h0);
    chk("abort_ready", {15'b0, in_ready}, 16'h1);
    chk("abort_flags", {12'b0, flags}, 16'h0);
    chk("abort_result", result, 16'h0);
    chk("abort_ar", alu_ar, 16'h0);
    chk("abort_ir", alu_ir, 16'h0);
    rd_chk("abort_r1", 3'd1, 16'h0);
    rd_chk("abort_r2", 3'd2, 16'h0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort_no_done", seen[15:0], 16'd0);
    chk("abort_ready_after", {15'b0, in_ready}, 16'h1);
    rd_chk("abort_r2_after", 3'd2, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
